// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Owns the PC, issues word-aligned
// requests to an in-order handshaked instruction memory, buffers returned
// words with their PCs and hands them to decode one per cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   taken branch: flush and refetch from target
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_resp_valid/inst          in-order response channel from memory
//   inst_valid/ready, inst, inst_pc  head-of-queue interface to decode
//
// state | meaning
// RUN   | normal fetch: requests issued, responses queued, head presented
// FLUSH | waiting for responses of discarded requests to drain; no issue
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [63:0]   fetch_pc;
    logic [63:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   inst_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   credits_used;
    logic [63:0]   redirect_target;

    // Datapath helpers
    always_comb begin
        redirect_target  = redirect_pc & ~64'h3;
        credits_used     = {1'b0, count} + {1'b0, outstanding};
        req_fire         = imem_req_valid & imem_req_ready;
        resp_fire        = imem_resp_valid & ~rst;
        // A redirect kills any same-cycle push or pop; responses arriving in
        // FLUSH belong to discarded requests and only return their credit.
        push             = resp_fire & (state == RUN) & ~redirect_valid;
        pop              = inst_valid & inst_ready & ~redirect_valid;
        outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state. Any redirect, and every FLUSH cycle, lands in FLUSH
    // only while discarded requests are still in flight after this edge.
    always_comb begin
        state_next = state;
        if (redirect_valid || (state == FLUSH)) begin
            state_next = (outstanding_next != '0) ? FLUSH : RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        imem_req_valid = (state == RUN) && !redirect_valid && !rst &&
                         (credits_used < DEPTH_SUM);
        imem_req_addr  = fetch_pc;
        inst_valid     = (count != '0) && (state == RUN);
        inst           = inst_mem[head];
        inst_pc        = pc_mem[head];
    end

    // PCs, credit counter and queue storage
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 64'd4;
                end
                if (push) begin
                    inst_mem[tail] <= imem_resp_inst;
                    pc_mem[tail]   <= resp_pc;
                    tail           <= tail + 1'b1;
                    resp_pc        <= resp_pc + 64'd4;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Credit rule means a full queue never sees a push without a pop, and
    // memory never answers more requests than were accepted.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == DEPTH_CNT)));
    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && (outstanding == '0)));

endmodule
